// File: rtl/sprite_compositor.sv
// Block-grid sprite compositor. Renders up to NUM_OBJ rectangles on a grid
// of BLOCKING_FACTOR-pixel blocks, lowest index on top, through a 3-stage
// pixel pipeline, and reports which objects overlapped during each frame.
// Object parameters are shadowed once per frame in vertical blanking so a
// frame never tears.
//
// Handshake: there is no valid/ready flow control. Exactly one hc/vc sample
// is consumed on every clock, and color_8bit/hit_idx for that sample appear
// three clocks later. collision_valid is a one-cycle strobe that marks a new
// collision value. Nothing can stall the pipeline.
module sprite_compositor #(
  parameter int BIT_WIDTH       = 8,
  parameter int NUM_OBJ         = 4,
  parameter int BLOCKING_FACTOR = 20,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic                           clk,
  input  logic                           sysRst,
  input  logic [9:0]                     hc,
  input  logic [9:0]                     vc,
  input  logic [NUM_OBJ*BIT_WIDTH-1:0]   obj_x,
  input  logic [NUM_OBJ*BIT_WIDTH-1:0]   obj_y,
  input  logic [NUM_OBJ*BIT_WIDTH-1:0]   obj_w,
  input  logic [NUM_OBJ*BIT_WIDTH-1:0]   obj_h,
  input  logic [NUM_OBJ*8-1:0]           obj_color,
  input  logic [NUM_OBJ-1:0]             obj_en,
  output logic [7:0]                     color_8bit,
  output logic [3:0]                     hit_idx,
  output logic [NUM_OBJ-1:0]             collision,
  output logic                           collision_valid
);

  // Compare width: wide enough for a block counter and for edge+size.
  localparam int CW = (BIT_WIDTH + 1 > 10) ? BIT_WIDTH + 1 : 10;
  localparam logic [5:0] BF_LAST = 6'(BLOCKING_FACTOR - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);

  logic latch;

  // Shadow copies of the object inputs.
  logic [NUM_OBJ*BIT_WIDTH-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [NUM_OBJ*BIT_WIDTH-1:0] sh_w_q, sh_w_d, sh_h_q, sh_h_d;
  logic [NUM_OBJ*8-1:0]         sh_color_q, sh_color_d;
  logic [NUM_OBJ-1:0]           sh_en_q, sh_en_d;

  // Stage 1: block counters and active flag.
  logic [5:0] hs_q, hs_d, vs_q, vs_d;
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic       act1_q, act1_d;

  // Stage 2: hit vector.
  logic [NUM_OBJ-1:0] hit_q, hit_d;
  logic               act2_q, act2_d;

  // Stage 3: composited pixel.
  logic [7:0] color_q, color_d;
  logic [3:0] idx_q, idx_d;

  // Collision tracking.
  logic [NUM_OBJ-1:0] contrib;
  logic [NUM_OBJ-1:0] acc_q, acc_d, coll_q, coll_d;
  logic               cval_q, cval_d;

  assign latch = (hc == 10'd0) && (vc == V_ACT);

  // Shadow registers load only at the frame latch point.
  always_comb begin
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_w_d     = sh_w_q;
    sh_h_d     = sh_h_q;
    sh_color_d = sh_color_q;
    sh_en_d    = sh_en_q;
    if (latch) begin
      sh_x_d     = obj_x;
      sh_y_d     = obj_y;
      sh_w_d     = obj_w;
      sh_h_d     = obj_h;
      sh_color_d = obj_color;
      sh_en_d    = obj_en;
    end
  end

  // Stage 1: divider-free block counters tracking hc/BF and vc/BF.
  always_comb begin
    hs_d   = hs_q;
    bx_d   = bx_q;
    vs_d   = vs_q;
    by_d   = by_q;
    act1_d = (hc < H_ACT) && (vc < V_ACT);
    if (hc == 10'd0) begin
      hs_d = 6'd0;
      bx_d = 10'd0;
      if (vc == 10'd0) begin
        vs_d = 6'd0;
        by_d = 10'd0;
      end else if (vs_q == BF_LAST) begin
        vs_d = 6'd0;
        by_d = by_q + 10'd1;
      end else begin
        vs_d = vs_q + 6'd1;
      end
    end else if (hs_q == BF_LAST) begin
      hs_d = 6'd0;
      bx_d = bx_q + 10'd1;
    end else begin
      hs_d = hs_q + 6'd1;
    end
  end

  // Stage 2: per-object rectangle test against the shadowed geometry.
  always_comb begin
    act2_d = act1_q;
    hit_d  = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      hit_d[i] = sh_en_q[i]
        && (CW'(bx_q) >= CW'(sh_x_q[i*BIT_WIDTH +: BIT_WIDTH]))
        && (CW'(bx_q) <  CW'(sh_x_q[i*BIT_WIDTH +: BIT_WIDTH]) + CW'(sh_w_q[i*BIT_WIDTH +: BIT_WIDTH]))
        && (CW'(by_q) >= CW'(sh_y_q[i*BIT_WIDTH +: BIT_WIDTH]))
        && (CW'(by_q) <  CW'(sh_y_q[i*BIT_WIDTH +: BIT_WIDTH]) + CW'(sh_h_q[i*BIT_WIDTH +: BIT_WIDTH]));
    end
  end

  // Stage 3: lowest hitting index wins; blanking forces black.
  always_comb begin
    color_d = BG_COLOR;
    idx_d   = 4'hF;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        color_d = sh_color_q[i*8 +: 8];
        idx_d   = 4'(i);
      end
    end
    if (!act2_q) begin
      color_d = 8'h00;
      idx_d   = 4'hF;
    end
  end

  // Sticky overlap accumulator, published and cleared at the latch point.
  always_comb begin
    contrib = (act2_q && ((hit_q & (hit_q - NUM_OBJ'(1))) != '0)) ? hit_q : '0;
    acc_d   = latch ? contrib : (acc_q | contrib);
    coll_d  = latch ? acc_q : coll_q;
    cval_d  = latch;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sysRst) begin
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_w_q     <= '0;
      sh_h_q     <= '0;
      sh_color_q <= '0;
      sh_en_q    <= '0;
      hs_q       <= '0;
      bx_q       <= '0;
      vs_q       <= '0;
      by_q       <= '0;
      act1_q     <= 1'b0;
      hit_q      <= '0;
      act2_q     <= 1'b0;
      color_q    <= 8'h00;
      idx_q      <= 4'hF;
      acc_q      <= '0;
      coll_q     <= '0;
      cval_q     <= 1'b0;
    end else begin
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_w_q     <= sh_w_d;
      sh_h_q     <= sh_h_d;
      sh_color_q <= sh_color_d;
      sh_en_q    <= sh_en_d;
      hs_q       <= hs_d;
      bx_q       <= bx_d;
      vs_q       <= vs_d;
      by_q       <= by_d;
      act1_q     <= act1_d;
      hit_q      <= hit_d;
      act2_q     <= act2_d;
      color_q    <= color_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      coll_q     <= coll_d;
      cval_q     <= cval_d;
    end
  end

  assign color_8bit      = color_q;
  assign hit_idx         = idx_q;
  assign collision       = coll_q;
  assign collision_valid = cval_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: frames of continuous hc runs per line with
// short horizontal blanking tails, directed object layouts followed by random
// ones, object inputs changed mid-frame, and one mid-frame reset. Expected
// pixels and collision flags come from a rectangle-arithmetic model.
module tb_sprite_compositor;
  localparam int N  = 3;
  localparam int BW = 8;
  localparam int BF = 20;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam logic [7:0] BG = 8'h00;

  // Clock and reset signals
  logic clk;
  logic sysRst;
  logic [9:0] hc, vc;
  logic [N*BW-1:0] obj_x, obj_y, obj_w, obj_h;
  logic [N*8-1:0]  obj_color;
  logic [N-1:0]    obj_en;
  logic [7:0]      color_8bit;
  logic [3:0]      hit_idx;
  logic [N-1:0]    collision;
  logic            collision_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sprite_compositor #(.NUM_OBJ(N)) dut (
    .clk(clk), .sysRst(sysRst), .hc(hc), .vc(vc),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_color(obj_color), .obj_en(obj_en),
    .color_8bit(color_8bit), .hit_idx(hit_idx),
    .collision(collision), .collision_valid(collision_valid)
  );

  // Object inputs as arrays, packed onto the DUT buses.
  logic [7:0] ox[N], oy[N], ow[N], oh[N], oc[N];
  logic [N-1:0] oen;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      obj_x[i*BW +: BW]  = ox[i];
      obj_y[i*BW +: BW]  = oy[i];
      obj_w[i*BW +: BW]  = ow[i];
      obj_h[i*BW +: BW]  = oh[i];
      obj_color[i*8 +: 8] = oc[i];
    end
    obj_en = oen;
  end

  // Reference model state: latched objects, overlap accumulator.
  logic [7:0] sx[N], sy[N], sw[N], sh[N], sc[N];
  logic [N-1:0] sen;
  logic [N-1:0] m_acc, exp_coll;

  // Scoreboard
  logic [11:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (hc=%0d vc=%0d t=%0t)", tag, got, exp, hc, vc, $time);
    end
  endtask

  // Pixel rule: pixel (h,v) lies in block (h/BF, v/BF); lowest hitting index on top.
  function automatic void model_px(input int h, input int v, output logic [7:0] col,
                                   output logic [3:0] idx, output logic [N-1:0] hits);
    int bxx, byy;
    bxx  = h / BF;
    byy  = v / BF;
    hits = '0;
    col  = 8'h00;
    idx  = 4'hF;
    if (h < HA && v < VA) begin
      col = BG;
      for (int i = 0; i < N; i++) begin
        hits[i] = sen[i] && bxx >= int'(sx[i]) && bxx < int'(sx[i]) + int'(sw[i])
                         && byy >= int'(sy[i]) && byy < int'(sy[i]) + int'(sh[i]);
        if (hits[i] && idx == 4'hF) begin
          col = sc[i];
          idx = 4'(i);
        end
      end
    end
  endfunction

  // Driver: one pixel sample, checked against the output for the sample two edges earlier.
  task automatic drive_px(input int h, input int v);
    logic [7:0] c;
    logic [3:0] ix;
    logic [N-1:0] hv;
    logic is_latch;
    logic [11:0] e;
    model_px(h, v, c, ix, hv);
    exp_q.push_back({c, ix});
    is_latch = (h == 0 && v == VA);
    if (is_latch) begin
      exp_coll = m_acc;
      m_acc = '0;
      sx = ox; sy = oy; sw = ow; sh = oh; sc = oc; sen = oen;
    end else if ($countones(hv) >= 2) begin
      m_acc = m_acc | hv;
    end
    hc = 10'(h);
    vc = 10'(v);
    sysRst = 1'b0;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("color", color_8bit, e[11:4]);
    check_eq("hit_idx", hit_idx, e[3:0]);
    check_eq("collision", collision, exp_coll);
    check_eq("coll_valid", collision_valid, is_latch);
  endtask

  // Driver: one reset cycle with a pixel sample presented alongside it.
  task automatic do_reset(input int h, input int v);
    hc = 10'(h);
    vc = 10'(v);
    sysRst = 1'b1;
    @(posedge clk);
    #1;
    sysRst = 1'b0;
    check_eq("rst_color", color_8bit, 8'h00);
    check_eq("rst_hit_idx", hit_idx, 4'hF);
    check_eq("rst_collision", collision, '0);
    check_eq("rst_coll_valid", collision_valid, 1'b0);
    for (int i = 0; i < N; i++) begin
      sx[i] = '0; sy[i] = '0; sw[i] = '0; sh[i] = '0; sc[i] = '0;
    end
    sen = '0;
    m_acc = '0;
    exp_coll = '0;
    exp_q.delete();
    exp_q.push_back({8'h00, 4'hF});
    exp_q.push_back({8'h00, 4'hF});
  endtask

  // Driver: a line of continuous hc from 0, then a short blanking tail.
  task automatic drive_line(input int v, input int len, input int rst_h);
    for (int h = 0; h < len; h++) begin
      if (h == rst_h) do_reset(h, v);
      else drive_px(h, v);
    end
    for (int h = HA; h < HA + 3; h++) drive_px(h, v);
  endtask

  // Object layouts: 0 = overlapping pair plus far-right object, 1 = pair moved apart, 2 = random.
  task automatic set_cfg(input int kind);
    if (kind < 2) begin
      ox[0] = (kind == 0) ? 8'd2 : 8'd5; oy[0] = 8'd3; ow[0] = 8'd1; oh[0] = 8'd4; oc[0] = 8'hE0;
      ox[1] = 8'd2;   oy[1] = 8'd3; ow[1] = 8'd1; oh[1] = 8'd1;  oc[1] = 8'h03;
      ox[2] = 8'd255; oy[2] = 8'd0; ow[2] = 8'd2; oh[2] = 8'd24; oc[2] = 8'h1C;
      oen = 3'b111;
    end else begin
      for (int i = 0; i < N; i++) begin
        ox[i]  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 33));
        oy[i]  = 8'($urandom_range(0, 25));
        ow[i]  = 8'($urandom_range(0, 8));
        oh[i]  = 8'($urandom_range(0, 8));
        oc[i]  = 8'($urandom_range(1, 255));
        oen[i] = ($urandom_range(0, 3) != 0);
      end
    end
  endtask

  initial begin
    int len, rst_h;
    sysRst = 1'b1;
    hc = '0;
    vc = '0;
    for (int i = 0; i < N; i++) begin
      ox[i] = '0; oy[i] = '0; ow[i] = '0; oh[i] = '0; oc[i] = '0;
    end
    oen = '0;
    do_reset(0, 0);
    for (int f = 0; f < 7; f++) begin
      for (int v = 0; v < VA + 3; v++) begin
        if (v == 200) set_cfg((f == 0) ? 0 : (f == 1) ? 1 : 2);
        if (v >= VA) len = 1;
        else if (v == 60 || v == 100 || v == 200 || $urandom_range(0, 199) == 0) len = HA;
        else len = $urandom_range(1, 16);
        rst_h = (f == 4 && v == 100) ? 300 : -1;
        drive_line(v, len, rst_h);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter BIT_WIDTH, default 8: width of block-grid coordinates and sizes.
REQ-002 Parameter NUM_OBJ, default 4: number of rectangular objects; legal range 1..16.
REQ-003 Parameter BLOCKING_FACTOR, default 20: pixels per grid block edge; legal range 1..64.
REQ-004 Parameter H_ACTIVE, default 640, and V_ACTIVE, default 480: visible pixel extent.
REQ-005 Parameter BG_COLOR, default 8'h00: RGB332 background colour.
REQ-006 Port clk, input, 1: pixel clock; exactly one hc/vc sample per cycle.
REQ-007 Port sysRst, input, 1: reset; one clock, synchronous, active-high.
REQ-008 Port hc, input, 10: horizontal pixel count, 0 at line start, +1 per cycle.
REQ-009 Port vc, input, 10: vertical line count, 0 at frame start.
REQ-010 Port obj_x, input, NUM_OBJ*BIT_WIDTH: per-object left edge in blocks; object i occupies slice [i*BIT_WIDTH +: BIT_WIDTH].
REQ-011 Port obj_y, input, NUM_OBJ*BIT_WIDTH: per-object top edge in blocks.
REQ-012 Port obj_w, input, NUM_OBJ*BIT_WIDTH: per-object width in blocks; 0 means never drawn.
REQ-013 Port obj_h, input, NUM_OBJ*BIT_WIDTH: per-object height in blocks; 0 means never drawn.
REQ-014 Port obj_color, input, NUM_OBJ*8: per-object RGB332 colour.
REQ-015 Port obj_en, input, NUM_OBJ: per-object enable.
REQ-016 Port color_8bit, output, 8: composited RGB332 pixel.
REQ-017 Port hit_idx, output, 4: index of the drawn object; 4'hF when background or blanked.
REQ-018 Port collision, output, NUM_OBJ: per-object overlap flags for the last completed frame.
REQ-019 Port collision_valid, output, 1: one-cycle pulse when collision updates.

Function
REQ-020 Shadow registers SHALL capture all obj_* inputs in the cycle where hc==0 and vc==V_ACTIVE (frame latch point); rendering SHALL use shadow values only, so mid-frame input changes never tear.
REQ-021 No dividers: block column bx and sub-counter hs SHALL reset to 0 when hc==0; otherwise hs increments, and on hs==BLOCKING_FACTOR-1 hs wraps to 0 and bx increments.
REQ-022 When hc==0: if vc==0, by and vs SHALL reset to 0; otherwise vs increments, and on vs==BLOCKING_FACTOR-1 vs wraps to 0 and by increments.
REQ-023 Object i hits when shadow en[i] is set, bx>=x, bx<x+w, by>=y and by<y+h; sums SHALL be computed at BIT_WIDTH+1 bits so edge+size never wraps.
REQ-024 Priority: the lowest hitting index SHALL win; color_8bit = obj_color of that object, otherwise BG_COLOR.
REQ-025 Outside the active area (hc>=H_ACTIVE or vc>=V_ACTIVE), color_8bit SHALL be 8'h00 and hit_idx 4'hF.
REQ-026 Pipeline: stage 1 registers the block counters and the active flag; stage 2 registers the hit vector; stage 3 registers color_8bit and hit_idx. Output latency SHALL be 3 cycles from the hc/vc sample.
REQ-027 Collision accumulator: during active pixels, when two or more objects hit, each hitting object's accumulator bit SHALL be set; bits are sticky within a frame.
REQ-028 At the frame latch point, collision SHALL load the accumulator, collision_valid SHALL pulse high for exactly one cycle, and the accumulator SHALL clear; a hit in that same cycle is counted in the new frame.
REQ-029 Rendering of the frame in progress SHALL be unaffected by the latch cycle, because it occurs in vertical blanking.

Reset
REQ-030 On sysRst, the shadow registers, counters, pipeline, accumulator, collision and collision_valid SHALL be 0; color_8bit SHALL be 8'h00 and hit_idx 4'hF.
REQ-031 After reset and until the first frame latch, all shadow enables are 0, so only BG_COLOR or blank is output.
REQ-032 Reset asserted mid-frame SHALL take effect on the next clock edge; output resumes at the 3-cycle latency after the next hc/vc sample.

Verification
REQ-033 Defaults, NUM_OBJ=3. Obj0 at x=2, y=3, w=1, h=4, colour E0, enabled, latched. Then pixel hc=40, vc=60 -> color_8bit=E0 and hit_idx=0 three cycles later. Pixel hc=60, vc=60 -> 00, F.
REQ-034 Obj0 as above and obj1 with colour 03 covering the same block -> colour E0. After the next latch point -> collision=3'b011 and collision_valid high for 1 cycle.
REQ-035 obj_x changes at hc=100, vc=200 -> rendering unchanged until after the vc=480 latch. The next frame shows the new position.
REQ-036 Object with x=255, w=2 (BIT_WIDTH=8) -> no wrap, and block column 0 is not drawn. Object with w=0 -> never drawn.
REQ-037 sysRst pulsed at hc=300, vc=100 -> the next cycle shows collision=0 and hit_idx=F, and only 00 is output until the next latch.
REQ-038 hc=640 or vc=480 with an object covering the region -> color_8bit=00.
